// File: rtl/fp5_accum_if.sv
// Stream-in / result-out bundle between the fp5 product source, the accumulator and its consumer.
// master = producer/consumer side, slave = fp5_accum.
interface fp5_accum_if #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [4:0]              in_data;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_acc;
  logic [4:0]              out_fp5;
  logic                    out_sat;
  logic [CNT_W-1:0]        out_cnt;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_fp5, out_sat, out_cnt
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_fp5, out_sat, out_cnt
  );
endinterface

// File: rtl/fp5_accum.sv
// Saturating fixed-point accumulator for fp5 product vectors; returns each vector sum as
// fixed-point (LSB = 1/16) and re-encoded as fp5.
module fp5_accum #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  fp5_accum_if.slave  bus
);

  typedef enum logic {ACCUM, DONE} state_e;

  localparam logic signed [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

  state_e                  state_q;
  logic                    s1_valid_q;
  logic                    s1_last_q;
  logic signed [9:0]       s1_val_q;
  logic signed [ACC_W-1:0] acc_q;
  logic                    sat_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    out_valid_q;
  logic signed [ACC_W-1:0] out_acc_q;
  logic [4:0]              out_fp5_q;
  logic                    out_sat_q;
  logic [CNT_W-1:0]        out_cnt_q;

  logic                    accept;
  logic [8:0]              dec_mag;
  logic signed [9:0]       dec_val;
  logic signed [ACC_W:0]   sum_wide;
  logic signed [ACC_W-1:0] sum_d;
  logic                    clamp_d;
  logic [CNT_W-1:0]        cnt_d;
  logic [4:0]              fp5_d;

  // Nearest, ties-away rounding on the guard bit only; 0.125 folds to zero since x0000 is reserved.
  function automatic logic [4:0] encode_fp5(input logic signed [ACC_W-1:0] a);
    logic           s;
    logic [ACC_W:0] m;
    logic [ACC_W:0] sh;
    int             p;
    logic [3:0]     e;
    logic           mb;
    logic           g;
    logic [4:0]     r;
    s  = a[ACC_W-1];
    m  = s ? ((ACC_W+1)'(0) - {a[ACC_W-1], a}) : {1'b0, a};
    p  = -1;
    for (int i = 0; i <= ACC_W; i++) begin
      if (m[i]) p = i;
    end
    r  = '0;
    e  = '0;
    mb = 1'b0;
    g  = 1'b0;
    sh = '0;
    if (p > 8) begin
      r = {s, 4'b1111};
    end else if (p >= 1) begin
      e = 4'(p - 1);
      if (p >= 2) begin
        sh = m >> (p - 2);
        mb = sh[1];
        g  = sh[0];
      end else begin
        mb = m[0];
      end
      if (g) begin
        if (mb) begin
          mb = 1'b0;
          e  = e + 4'd1;
        end else begin
          mb = 1'b1;
        end
      end
      if (e > 4'd7)            r = {s, 4'b1111};
      else if (e == 4'd0 && !mb) r = 5'b00000;
      else                     r = {s, e[2:0], mb};
    end
    return r;
  endfunction

  assign bus.in_ready = rst_ni & (state_q == ACCUM) & ~(s1_valid_q & s1_last_q);
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    dec_mag = 9'({1'b1, bus.in_data[0]}) << bus.in_data[3:1];
    if (bus.in_data[3:0] == 4'd0) dec_mag = '0;
    dec_val = bus.in_data[4] ? -$signed({1'b0, dec_mag}) : $signed({1'b0, dec_mag});
  end

  // One guard bit above the accumulator exposes overflow; the two top bits disagree on overflow.
  always_comb begin
    sum_wide = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-9){s1_val_q[9]}}, s1_val_q};
    clamp_d  = sum_wide[ACC_W] != sum_wide[ACC_W-1];
    if (clamp_d) sum_d = sum_wide[ACC_W] ? AccMin : AccMax;
    else         sum_d = sum_wide[ACC_W-1:0];
    cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    fp5_d = encode_fp5(sum_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ACCUM;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_val_q    <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_fp5_q   <= '0;
      out_sat_q   <= 1'b0;
      out_cnt_q   <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_last_q <= bus.in_last;
        s1_val_q  <= dec_val;
      end
      if (s1_valid_q) begin
        if (s1_last_q) begin
          out_acc_q   <= sum_d;
          out_fp5_q   <= fp5_d;
          out_sat_q   <= sat_q | clamp_d;
          out_cnt_q   <= cnt_d;
          out_valid_q <= 1'b1;
          acc_q       <= '0;
          sat_q       <= 1'b0;
          cnt_q       <= '0;
          state_q     <= DONE;
        end else begin
          acc_q <= sum_d;
          sat_q <= sat_q | clamp_d;
          cnt_q <= cnt_d;
        end
      end
      if (state_q == DONE && bus.out_ready) begin
        out_valid_q <= 1'b0;
        state_q     <= ACCUM;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = out_acc_q;
  assign bus.out_fp5   = out_fp5_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_fp5_accum.sv
// Directed bench for fp5_accum: hand-computed vector sums, fp5 encoding corners,
// saturation, back-pressure and mid-vector reset.
module tb_fp5_accum;

  logic clk;
  logic rst_n;
  int   total;
  int   passes;

  fp5_accum_if #(.ACC_W(16), .CNT_W(8)) bus ();

  fp5_accum #(.ACC_W(16), .CNT_W(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge after the beat was taken.
  task automatic drive_beat(input logic [4:0] d, input logic l);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 50) $display("[TB] FAIL accept_timeout: in_ready got %b want 1", bus.in_ready);
    else passes++;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_vec(input logic [4:0] d, input int n);
    for (int i = 0; i < n; i++) drive_beat(d, i == n - 1);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 300) $display("[TB] FAIL result_timeout: out_valid got %b want 1", bus.out_valid);
    else passes++;
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) $display("[TB] FAIL rst_hs: valid/ready got %b/%b want 0/0", bus.out_valid, bus.in_ready); else passes++;
    total++; if (bus.out_acc !== 16'sd0 || bus.out_cnt !== 8'd0 || bus.out_fp5 !== 5'd0) $display("[TB] FAIL rst_out: acc %0d cnt %0d fp5 %b want 0", bus.out_acc, bus.out_cnt, bus.out_fp5); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL rst_ready: got %b want 1", bus.in_ready); else passes++;
  endtask

  task automatic test_basic();
    send_vec(5'b00110, 3);
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) $display("[TB] FAIL t1_lat0: valid/ready got %b/%b want 0/0", bus.out_valid, bus.in_ready); else passes++;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL t1_lat1: out_valid got %b want 1", bus.out_valid); else passes++;
    total++; if (bus.out_acc !== 16'sd48) $display("[TB] FAIL t1_acc: got %0d want 48", bus.out_acc); else passes++;
    total++; if (bus.out_fp5 !== 5'b01001) $display("[TB] FAIL t1_fp5: got %b want 01001", bus.out_fp5); else passes++;
    total++; if (bus.out_cnt !== 8'd3 || bus.out_sat !== 1'b0) $display("[TB] FAIL t1_cnt_sat: got %0d/%b want 3/0", bus.out_cnt, bus.out_sat); else passes++;
    release_result();
  endtask

  task automatic test_cancel();
    drive_beat(5'b00110, 1'b0);
    drive_beat(5'b10110, 1'b1);
    wait_valid();
    total++; if (bus.out_acc !== 16'sd0 || bus.out_fp5 !== 5'b00000) $display("[TB] FAIL t2_sum: acc %0d fp5 %b want 0 00000", bus.out_acc, bus.out_fp5); else passes++;
    total++; if (bus.out_cnt !== 8'd2) $display("[TB] FAIL t2_cnt: got %0d want 2", bus.out_cnt); else passes++;
    release_result();
  endtask

  task automatic test_round();
    drive_beat(5'b00110, 1'b0);
    drive_beat(5'b00010, 1'b1);
    wait_valid();
    total++; if (bus.out_acc !== 16'sd20) $display("[TB] FAIL t3_acc: got %0d want 20", bus.out_acc); else passes++;
    total++; if (bus.out_fp5 !== 5'b00111) $display("[TB] FAIL t3_fp5: got %b want 00111", bus.out_fp5); else passes++;
    release_result();
  endtask

  task automatic test_negative();
    drive_beat(5'b10110, 1'b0);
    drive_beat(5'b10100, 1'b1);
    wait_valid();
    total++; if (bus.out_acc !== -16'sd24) $display("[TB] FAIL neg_acc: got %0d want -24", bus.out_acc); else passes++;
    total++; if (bus.out_fp5 !== 5'b10111) $display("[TB] FAIL neg_fp5: got %b want 10111", bus.out_fp5); else passes++;
    release_result();
  endtask

  task automatic test_reserved_code();
    drive_beat(5'b00011, 1'b0);
    drive_beat(5'b10010, 1'b1);
    wait_valid();
    total++; if (bus.out_acc !== 16'sd2 || bus.out_fp5 !== 5'b00000) $display("[TB] FAIL eighth: acc %0d fp5 %b want 2 00000", bus.out_acc, bus.out_fp5); else passes++;
    release_result();
  endtask

  task automatic test_zero_beats();
    drive_beat(5'b00000, 1'b0);
    drive_beat(5'b10000, 1'b1);
    wait_valid();
    total++; if (bus.out_acc !== 16'sd0 || bus.out_cnt !== 8'd2 || bus.out_fp5 !== 5'b00000) $display("[TB] FAIL zeros: acc %0d cnt %0d fp5 %b want 0 2 00000", bus.out_acc, bus.out_cnt, bus.out_fp5); else passes++;
    release_result();
    send_vec(5'b00000, 260);
    wait_valid();
    total++; if (bus.out_cnt !== 8'd255 || bus.out_sat !== 1'b0) $display("[TB] FAIL cnt_sat: cnt %0d sat %b want 255 0", bus.out_cnt, bus.out_sat); else passes++;
    release_result();
  endtask

  task automatic test_saturate();
    send_vec(5'b01111, 90);
    wait_valid();
    total++; if (bus.out_acc !== 16'sd32767) $display("[TB] FAIL t4_acc: got %0d want 32767", bus.out_acc); else passes++;
    total++; if (bus.out_sat !== 1'b1) $display("[TB] FAIL t4_sat: got %b want 1", bus.out_sat); else passes++;
    total++; if (bus.out_fp5 !== 5'b01111 || bus.out_cnt !== 8'd90) $display("[TB] FAIL t4_fp5_cnt: got %b/%0d want 01111/90", bus.out_fp5, bus.out_cnt); else passes++;
    release_result();
  endtask

  task automatic test_back_to_back();
    send_vec(5'b01001, 1);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_acc !== 16'sd48 || bus.out_fp5 !== 5'b01001 || bus.out_cnt !== 8'd1)
        $display("[TB] FAIL t5_hold%0d: valid %b ready %b acc %0d fp5 %b cnt %0d want 1 0 48 01001 1", i, bus.out_valid, bus.in_ready, bus.out_acc, bus.out_fp5, bus.out_cnt);
      else passes++;
    end
    release_result();
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_acc !== 16'sd48) $display("[TB] FAIL t5_release: valid %b ready %b acc %0d want 0 1 48", bus.out_valid, bus.in_ready, bus.out_acc); else passes++;
    send_vec(5'b00110, 1);
    wait_valid();
    total++; if (bus.out_acc !== 16'sd16 || bus.out_cnt !== 8'd1 || bus.out_fp5 !== 5'b00110) $display("[TB] FAIL t5_next: acc %0d cnt %0d fp5 %b want 16 1 00110", bus.out_acc, bus.out_cnt, bus.out_fp5); else passes++;
    release_result();
  endtask

  task automatic test_reset_mid();
    drive_beat(5'b01111, 1'b0);
    drive_beat(5'b01111, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.out_acc !== 16'sd0 || bus.out_cnt !== 8'd0 || bus.out_fp5 !== 5'd0) $display("[TB] FAIL t6_async: acc %0d cnt %0d fp5 %b want 0", bus.out_acc, bus.out_cnt, bus.out_fp5); else passes++;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) $display("[TB] FAIL t6_hs: valid/ready got %b/%b want 0/0", bus.out_valid, bus.in_ready); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_vec(5'b01001, 1);
    wait_valid();
    total++; if (bus.out_acc !== 16'sd48 || bus.out_cnt !== 8'd1 || bus.out_sat !== 1'b0) $display("[TB] FAIL t6_after: acc %0d cnt %0d sat %b want 48 1 0", bus.out_acc, bus.out_cnt, bus.out_sat); else passes++;
    release_result();
  endtask

  initial begin
    total         = 0;
    passes        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 5'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_cancel();
    test_round();
    test_negative();
    test_reserved_code();
    test_zero_beats();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
